// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: advance, multi-cycle hold, redirect and sticky halt.
// Define PC_PERF_CNT_EN to build the retire/stall performance counters.
module pc_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int RESET_VEC = 0,
    parameter int STEP      = 4,
    parameter int END_ADDR  = 32764,
    parameter int HCNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              hold_req,
    input  logic [HCNT_W-1:0] hold_cycles,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              busy,
    output logic              halted,
    output logic [31:0]       retire_cnt,
    output logic [31:0]       stall_cnt
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] LIMIT  = ADDR_W'(END_ADDR);
    localparam logic [ADDR_W-1:0] INC    = ADDR_W'(STEP);

    typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

    state_t            state, state_nx;
    logic [HCNT_W-1:0] hold_cnt, hold_nx;
    logic [ADDR_W-1:0] target, pc_nx;
    logic              load, legal;

    assign pc_next = pc + INC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RST_PC;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        target   = pc_next;
        load     = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect_valid) begin
                    target = {redirect_addr[ADDR_W-1:2], 2'b00};
                    load   = 1'b1;
                end else if (en && hold_req && hold_cycles != '0) begin
                    state_nx = HOLD;
                    hold_nx  = hold_cycles;
                end else if (en) begin
                    load = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    target  = {redirect_addr[ADDR_W-1:2], 2'b00};
                    load    = 1'b1;
                    hold_nx = '0;
                end else if (hold_cnt == HCNT_W'(1)) begin
                    load    = 1'b1;
                    hold_nx = '0;
                end else begin
                    hold_nx = hold_cnt - HCNT_W'(1);
                end
            end
            default: ;
        endcase
        // Every load is range-checked; an illegal target freezes pc and halts.
        legal = target < LIMIT;
        if (load) state_nx = legal ? RUN : HALT;
        pc_nx = (load && legal) ? target : pc;
    end

    always_comb begin
        busy   = (state == HOLD);
        halted = (state == HALT);
    end

`ifdef PC_PERF_CNT_EN
    logic retire_inc, stall_inc;

    assign retire_inc = load && legal;
    assign stall_inc  = (state == HOLD) || (state == RUN && !en);

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (retire_inc && retire_cnt != '1) retire_cnt <= retire_cnt + 32'd1;
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign retire_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule
